// File: rtl/mul32_seq_shift_add_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// default operand width, FSM state encoding and counter sizing.
package mul32_seq_shift_add_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } state_t;

    // Iteration counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/mul_twos_neg.sv
// N-bit two's-complement negator: invert, then add one.
module mul_twos_neg #(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    output logic [N-1:0] y
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    assign y = ~x + ONE;

endmodule

// File: rtl/mul32_seq_shift_add.sv
// Sequential radix-2 shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed operands are multiplied as magnitudes and the product is negated
// in a single extra cycle when the operand signs differ.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands; in_ready high
// RUN   | one shift-and-add iteration per cycle, WIDTH iterations
// FIX   | negate the full 2*WIDTH product (signed, signs differed)
// DONE  | product held on hi/lo; out_valid high until out_ready
module mul32_seq_shift_add
    import mul32_seq_shift_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic               neg_flag;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   a_neg;
    logic [WIDTH-1:0]   b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic               last_iter;

    mul_twos_neg #(.N(WIDTH)) u_neg_a (
        .x (a),
        .y (a_neg)
    );

    mul_twos_neg #(.N(WIDTH)) u_neg_b (
        .x (b),
        .y (b_neg)
    );

    mul_twos_neg #(.N(2*WIDTH)) u_neg_prod (
        .x ({hi, lo}),
        .y (prod_neg)
    );

    // |0x80..0| negates to itself, which is the right unsigned magnitude.
    assign a_abs = (is_signed && a[WIDTH-1]) ? a_neg : a;
    assign b_abs = (is_signed && b[WIDTH-1]) ? b_neg : b;

    // The extra top bit keeps the carry, which shifts into hi[MSB].
    assign addend    = lo[0] ? {1'b0, mcand} : '0;
    assign sum       = {1'b0, hi} + addend;
    assign last_iter = (cnt == CNT_LAST);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign zero      = ({hi, lo} == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; DONE always returns to IDLE before a new accept.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = RUN;
            RUN:  if (last_iter) state_nxt = neg_flag ? FIX : DONE;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, shift-and-add iterations and final sign fix-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            neg_flag <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= a_abs;
                        hi       <= '0;
                        lo       <= b_abs;
                        neg_flag <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    hi  <= sum[WIDTH:1];
                    lo  <= {sum[0], lo[WIDTH-1:1]};
                    cnt <= cnt + CNT_ONE;
                end
                FIX: begin
                    {hi, lo} <= prod_neg;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul32_seq_shift_add.sv
// Scoreboard bench for mul32_seq_shift_add. Expected products come from a
// behavioural 64-bit multiply; latency is counted with the accept edge as
// cycle 1, so out_valid after the last RUN iteration reads as 33.
module tb_mul32_seq_shift_add;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
        int          lat;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    mul32_seq_shift_add #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hi        (hi),
        .lo        (lo),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                             input logic s);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        if (s) return sx * sy;
        return {32'b0, x} * {32'b0, y};
    endfunction

    task automatic push_exp(input logic [31:0] x, input logic [31:0] y, input logic s,
                            input string nm);
        exp_t e;
        logic [63:0] p;
        p      = ref_prod(x, y, s);
        e.hi   = p[63:32];
        e.lo   = p[31:0];
        e.zero = (p == 64'd0);
        e.lat  = (s && (x[31] ^ y[31])) ? 34 : 33;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Waits for out_valid (lat already counts the accept edge) and checks
    // the product against the oldest scoreboard entry.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input string nm);
        int   w;
        int   lat;
        exp_t e;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s wait_in_ready: got %b required 1", nm, in_ready);
        end
        a = x; b = y; is_signed = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        push_exp(x, y, s, nm);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s in_ready_after_accept: got %b required 0", nm, in_ready);
        end
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        e = sb.pop_front();
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: out_valid got %b required 1", nm, out_valid);
        end
        n_tests++;
        if (hi !== e.hi) begin
            n_fail++;
            $display("FAIL %s hi: got %h required %h", nm, hi, e.hi);
        end
        n_tests++;
        if (lo !== e.lo) begin
            n_fail++;
            $display("FAIL %s lo: got %h required %h", nm, lo, e.lo);
        end
        n_tests++;
        if (zero !== e.zero) begin
            n_fail++;
            $display("FAIL %s zero: got %b required %b", nm, zero, e.zero);
        end
        n_tests++;
        if (lat != e.lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d required %0d", nm, lat, e.lat);
        end
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s return_idle: in_ready %b out_valid %b required 1 0",
                     nm, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: in_ready %b out_valid %b required 1 0",
                     in_ready, out_valid);
        end
        n_tests++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_product: hi %h lo %h required 0 0", hi, lo);
        end
        n_tests++;
        if (zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_zero: got %b required 1", zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        run_op(32'd7, 32'd6, 1'b0, "u_7x6");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_max_sq");
        run_op(32'h0, 32'h1234_5678, 1'b0, "u_zero");
    endtask

    task automatic test_signed();
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, "s_m3x5");
        run_op(32'hFFFF_FFFB, 32'd0, 1'b1, "s_m5x0");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, "s_min_sq");
        run_op(32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1, "s_m7xm6");
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, "s_min_x_max");
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t e;
        out_ready = 1'b0;
        a = 32'd7; b = 32'd6; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        push_exp(32'd7, 32'd6, 1'b0, "bp_first");
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        e = sb.pop_front();
        a = 32'd3; b = 32'd4; is_signed = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || hi !== e.hi || lo !== e.lo) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: out_valid %b in_ready %b hi %h lo %h required 1 0 %h %h",
                         i, out_valid, in_ready, hi, lo, e.hi, e.lo);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready %b out_valid %b required 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        push_exp(32'd3, 32'd4, 1'b0, "bp_second");
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: in_ready got %b required 0", in_ready);
        end
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        e = sb.pop_front();
        n_tests++;
        if (out_valid !== 1'b1 || hi !== e.hi || lo !== e.lo || lat != e.lat) begin
            n_fail++;
            $display("FAIL bp_second: out_valid %b hi %h lo %h lat %0d required 1 %h %h %0d",
                     out_valid, hi, lo, lat, e.hi, e.lo, e.lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        a = 32'h1234_5678; b = 32'h0765_4321; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_handshake: in_ready %b out_valid %b required 1 0",
                     in_ready, out_valid);
        end
        n_tests++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_product: hi %h lo %h required 0 0", hi, lo);
        end
        #7;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'd12, 32'd12, 1'b0, "post_rst_12x12");
    endtask

    task automatic test_back_to_back();
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        for (int i = 0; i < 6; i++) begin
            x = $urandom;
            y = $urandom;
            s = i[0];
            run_op(x, y, s, $sformatf("b2b_%0d", i));
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
